serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial SIZE-bit subtractor: one full-subtractor cell plus a borrow flop, start/busy/done handshake.
// Define SERIAL_SUB_SIGNED_OVF_EN to report two's-complement overflow instead of the unsigned borrow.
module serial_subtractor #(
   parameter int unsigned SIZE = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic            busy,
   output logic            done,
   output logic            overflow,
   output logic [SIZE:0]   result
);

   localparam int unsigned CW = $clog2(SIZE);
   localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [SIZE-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            bw_q, bw_d;
   logic [SIZE:0]   result_q, result_d;
   logic            ovf_q, ovf_d;
   logic            busy_q, busy_d, done_q, done_d;
   logic            a0, b0, d_bit, bw_next;

   always_comb begin
      a0      = a_q[0];
      b0      = b_q[0];
      d_bit   = a0 ^ b0 ^ bw_q;
      bw_next = (~a0 & b0) | (~(a0 ^ b0) & bw_q);

      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      bw_d     = bw_q;
      result_d = result_q;
      ovf_d    = ovf_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               bw_d    = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            diff_d = {d_bit, diff_q[SIZE-1:1]};
            a_d    = a_q >> 1;
            b_d    = b_q >> 1;
            bw_d   = bw_next;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d  = DONE;
               result_d = {bw_next, diff_d};
`ifdef SERIAL_SUB_SIGNED_OVF_EN
               // On the last bit a0/b0 are the operand MSBs captured at start.
               ovf_d = (a0 != b0) && (d_bit != a0);
`else
               ovf_d = bw_next;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         bw_q     <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         bw_q     <= bw_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;
   assign result   = result_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: SIZE=8 directed/random ops plus an exhaustive SIZE=2 instance.
module tb_serial_subtractor;

   typedef struct {
      int unsigned res;
      logic        ovf;
      int unsigned cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start8 = 1'b0, start2 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic [1:0] a2 = '0, b2 = '0;
   logic       busy8, done8, ovf8, busy2, done2, ovf2;
   logic [8:0] res8;
   logic [2:0] res2;

   int unsigned edges = 0;
   int          total = 0;
   int          bad = 0;
   exp_t        q8[$];
   exp_t        q2[$];

   always #5 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;

   serial_subtractor #(.SIZE(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .overflow(ovf8), .result(res8)
   );

   serial_subtractor #(.SIZE(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .overflow(ovf2), .result(res2)
   );

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: a-b from plain integer arithmetic on the operand values.
   function automatic exp_t model(input int unsigned size, input int unsigned a, input int unsigned b,
                                  input int unsigned cyc);
      exp_t e;
      int unsigned m;
      int sa, sb, sd;
      m = 1 << size;
      e.res = ((a + m - b) % m) | ((a < b) ? m : 0);
      sa = (a >= m / 2) ? int'(a) - int'(m) : int'(a);
      sb = (b >= m / 2) ? int'(b) - int'(m) : int'(b);
      sd = sa - sb;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      e.ovf = (sd < -int'(m / 2)) || (sd > int'(m / 2) - 1);
`else
      e.ovf = (a < b);
`endif
      e.cyc = cyc;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst && done8) begin
         if (q8.size() == 0) begin
            chk("done8_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = q8.pop_front();
            chk("res8", res8, e.res);
            chk("ovf8", ovf8, e.ovf);
            chk("lat8", edges, e.cyc);
            chk("busy8_in_done", busy8, 0);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && done2) begin
         if (q2.size() == 0) begin
            chk("done2_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = q2.pop_front();
            chk("res2", res2, e.res);
            chk("ovf2", ovf2, e.ovf);
            chk("lat2", edges, e.cyc);
         end
      end
   end

   // Called at a negedge; the following posedge is the start edge.
   task automatic issue8(input logic [7:0] a, input logic [7:0] b);
      a8 = a; b8 = b; start8 = 1'b1;
      q8.push_back(model(8, a, b, edges + 1 + 8));
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
   endtask

   task automatic issue2(input logic [1:0] a, input logic [1:0] b);
      a2 = a; b2 = b; start2 = 1'b1;
      q2.push_back(model(2, a, b, edges + 1 + 2));
      @(negedge clk);
      start2 = 1'b0;
   endtask

   task automatic wait_done8();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done8) return;
      end
      chk("done8_timeout", 0, 1);
   endtask

   task automatic wait_done2();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done2) return;
      end
      chk("done2_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_result", res8, 0);
      chk("rst_ovf", ovf8, 0);
      rst = 1'b0;
      @(negedge clk);

      issue8(8'd5, 8'd3);    wait_done8();
      @(negedge clk);
      issue8(8'd3, 8'd5);    wait_done8();
      @(negedge clk);
      issue8(8'h80, 8'h01);  wait_done8();
      @(negedge clk);

      // Start while busy must be dropped.
      issue8(8'd9, 8'd4);
      repeat (2) @(negedge clk);
      a8 = 8'd0; b8 = 8'd1; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      wait_done8();
      repeat (12) @(negedge clk);
      chk("ignored_start_idle", busy8, 0);

      // Abort mid-RUN; no done may follow.
      issue8(8'h55, 8'h22);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", busy8, 0);
      chk("abort_result", res8, 0);
      chk("abort_ovf", ovf8, 0);
      rst = 1'b0;
      q8.delete();
      repeat (20) @(negedge clk);
      chk("abort_no_done_busy", busy8, 0);

      // Back-to-back: second start issued in the DONE cycle.
      issue8(8'hFF, 8'hFF);
      wait_done8();
      issue8(8'h00, 8'h00);
      wait_done8();
      @(negedge clk);

      for (int n = 0; n < 30; n++) begin
         issue8(8'($urandom), 8'($urandom));
         wait_done8();
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      @(negedge clk);

      for (int unsigned i = 0; i < 16; i++) begin
         issue2(2'(i >> 2), 2'(i));
         wait_done2();
      end
      repeat (5) @(negedge clk);

      chk("q8_drained", q8.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
